ula_issue: RTL and testbench

ULA_ISSUE -- requirements
Module: ula_issue

---
 rtl/ula_issue_pkg.sv | 46 ++++
 rtl/ula_regfile.sv | 38 +++
 rtl/ula_issue.sv | 176 +++++++++++++++++
 tb/tb_ula_issue.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_issue_pkg.sv
// Shared definitions for the ula_issue serial RV32I issue block.
// Holds opcode/funct3 constants, the FSM state type, the ALU request
// payload and the 12-bit immediate sign-extension helper.
package ula_issue_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;
    localparam int unsigned IMM_W  = 12;

    localparam logic [OPC_W-1:0] OP_R = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_I = 7'b0010011;

    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SR   = 3'b101;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Operand/operation bundle presented to the external ALU.
    typedef struct packed {
        logic [XLEN-1:0]  data1;
        logic [XLEN-1:0]  data2;
        logic [OPC_W-1:0] opcode;
        logic [F3_W-1:0]  funct3;
        logic [F7_W-1:0]  funct7;
    } alu_req_t;

    function automatic logic [XLEN-1:0] sext_imm12(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/ula_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write
// port, one combinational debug read port. x0 reads 0, ignores writes.
// Ports: clk, rst_n; i_rs1_addr/o_rs1_data_c, i_rs2_addr/o_rs2_data_c;
//        i_we, i_wr_addr, i_wr_data; i_dbg_addr/o_dbg_data_c.
module ula_regfile
    import ula_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_rs1_addr,
    output logic [XLEN-1:0]   o_rs1_data_c,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic [XLEN-1:0]   o_rs2_data_c,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wr_addr,
    input  logic [XLEN-1:0]   i_wr_data,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [XLEN-1:0]   o_dbg_data_c
);

    logic [XLEN-1:0] r_regs [NREGS];

    // Storage; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rs1_data_c = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
    assign o_rs2_data_c = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];
    assign o_dbg_data_c = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/ula_issue.sv
// Serial RV32I R/I-type issue block: IDLE -> DECODE -> EXEC -> WB, one
// instruction per four cycles. Operands go to an external ALU; its
// result is captured and retired into the local register file.
// Ports: clk, rst_n; instr/instr_valid/instr_ready (accept);
//        alu_data1/2, alu_opcode/funct3/funct7 (to ALU), alu_result (from ALU);
//        wb_valid/wb_rd/wb_data (retire); illegal (bad opcode);
//        dbg_addr/dbg_data (combinational register read).
module ula_issue
    import ula_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [XLEN-1:0]   alu_data1,
    output logic [XLEN-1:0]   alu_data2,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [F3_W-1:0]   alu_funct3,
    output logic [F7_W-1:0]   alu_funct7,
    input  logic [XLEN-1:0]   alu_result,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    state_t            r_state;
    logic [XLEN-1:0]   r_instr;
    alu_req_t          r_alu;
    logic              r_wb_valid;
    logic [REG_AW-1:0] r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_illegal;

    state_t            w_state_nxt;
    logic [XLEN-1:0]   w_instr_nxt;
    alu_req_t          w_alu_nxt;
    logic              w_wb_valid_nxt;
    logic [REG_AW-1:0] w_wb_rd_nxt;
    logic [XLEN-1:0]   w_wb_data_nxt;
    logic              w_illegal_nxt;
    logic              w_rf_we;

    logic [XLEN-1:0]   w_rs1_data;
    logic [XLEN-1:0]   w_rs2_data;

    // Fields of the latched instruction.
    logic [OPC_W-1:0]  w_opcode;
    logic [REG_AW-1:0] w_rd;
    logic [F3_W-1:0]   w_funct3;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [F7_W-1:0]   w_funct7;
    logic [IMM_W-1:0]  w_imm;

    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_funct3 = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];
    assign w_funct7 = r_instr[31:25];
    assign w_imm    = r_instr[31:20];

    ula_regfile u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rs1_addr   (w_rs1),
        .o_rs1_data_c (w_rs1_data),
        .i_rs2_addr   (w_rs2),
        .o_rs2_data_c (w_rs2_data),
        .i_we         (w_rf_we),
        .i_wr_addr    (r_wb_rd),
        .i_wr_data    (r_wb_data),
        .i_dbg_addr   (dbg_addr),
        .o_dbg_data_c (dbg_data)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_instr_nxt    = r_instr;
        w_alu_nxt      = r_alu;
        w_wb_valid_nxt = 1'b0;
        w_wb_rd_nxt    = r_wb_rd;
        w_wb_data_nxt  = r_wb_data;
        w_illegal_nxt  = 1'b0;
        w_rf_we        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_instr_nxt = instr;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (w_opcode)
                    OP_R: begin
                        w_alu_nxt.data1  = w_rs1_data;
                        w_alu_nxt.data2  = w_rs2_data;
                        w_alu_nxt.opcode = OP_R;
                        w_alu_nxt.funct3 = w_funct3;
                        w_alu_nxt.funct7 = w_funct7;
                        w_state_nxt      = ST_EXEC;
                    end
                    OP_I: begin
                        // The ALU only speaks R-type; funct7 survives only
                        // for shifts, where it selects logical vs arithmetic.
                        w_alu_nxt.data1  = w_rs1_data;
                        w_alu_nxt.data2  = sext_imm12(w_imm);
                        w_alu_nxt.opcode = OP_R;
                        w_alu_nxt.funct3 = w_funct3;
                        w_alu_nxt.funct7 = ((w_funct3 == F3_SLL) || (w_funct3 == F3_SR))
                                           ? w_funct7 : F7_W'(0);
                        w_state_nxt      = ST_EXEC;
                    end
                    default: begin
                        w_illegal_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                endcase
            end
            ST_EXEC: begin
                w_wb_data_nxt  = alu_result;
                w_wb_rd_nxt    = w_rd;
                w_wb_valid_nxt = 1'b1;
                w_state_nxt    = ST_WB;
            end
            ST_WB: begin
                w_rf_we     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_instr    <= '0;
            r_alu      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_instr    <= w_instr_nxt;
            r_alu      <= w_alu_nxt;
            r_wb_valid <= w_wb_valid_nxt;
            r_wb_rd    <= w_wb_rd_nxt;
            r_wb_data  <= w_wb_data_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    // Ready is held low for the whole reset window, not just until the first edge.
    assign instr_ready = (r_state == ST_IDLE) && rst_n;

    assign alu_data1  = r_alu.data1;
    assign alu_data2  = r_alu.data2;
    assign alu_opcode = r_alu.opcode;
    assign alu_funct3 = r_alu.funct3;
    assign alu_funct7 = r_alu.funct7;
    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_ula_issue.sv
// Testbench for ula_issue: directed RV32I programs plus randomized
// instruction streams, checked every cycle against an instruction-level
// reference model, with a bench-side ALU attached to the alu_* ports.
module tb_ula_issue;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_data1, alu_data2;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ula_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_opcode  (alu_opcode),
        .alu_funct3  (alu_funct3),
        .alu_funct7  (alu_funct7),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external ALU (R-type encoding only).
    function automatic logic [31:0] ula(input logic [31:0] a, input logic [31:0] b,
                                        input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
        logic [31:0] r;
        if (op != 7'b0110011) return 32'h0;
        case (f3)
            3'd0: r = (f7 == 7'b0100000) ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = (f7 == 7'b0100000) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    always_comb alu_result = ula(alu_data1, alu_data2, alu_opcode, alu_funct3, alu_funct7);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    logic [31:0] m_regs [32];
    int          m_ph;          // -1 idle, else cycles since accept
    logic        m_ill;
    logic [31:0] m_ins;
    logic [31:0] m_res;
    logic [31:0] m_d1, m_d2;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;

    function automatic logic [31:0] sx12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    // RV32I semantics of ADD/SUB/SLL/... and their immediate forms.
    function automatic logic [31:0] rv_ref(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] rs2v);
        logic        is_i;
        logic [31:0] b;
        logic [4:0]  sh;
        is_i = (ins[6:0] == 7'b0010011);
        b    = is_i ? sx12(ins[31:20]) : rs2v;
        sh   = b[4:0];
        case (ins[14:12])
            3'd0: return (!is_i && ins[30]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_ph = -1; m_ill = 1'b0; m_ins = '0; m_res = '0;
        m_d1 = '0; m_d2 = '0; m_op = '0; m_f3 = '0; m_f7 = '0;
    endtask

    initial model_reset();

    // Compare DUT against model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready",    32'(instr_ready), 32'd0);
            chk("rst_wb_valid", 32'(wb_valid),    32'd0);
            chk("rst_illegal",  32'(illegal),     32'd0);
            chk("rst_wb_rd",    32'(wb_rd),       32'd0);
            chk("rst_wb_data",  wb_data,          32'd0);
            chk("rst_alu_d1",   alu_data1,        32'd0);
            chk("rst_alu_d2",   alu_data2,        32'd0);
            chk("rst_alu_op",   32'(alu_opcode),  32'd0);
            chk("rst_alu_f7",   32'(alu_funct7),  32'd0);
            chk("rst_dbg",      dbg_data,         32'd0);
            model_reset();
        end else begin
            chk("ready",    32'(instr_ready), 32'(m_ph < 0));
            chk("wb_valid", 32'(wb_valid),    32'(m_ph == 2));
            chk("illegal",  32'(illegal),     32'(m_ill));
            if (m_ph == 2) begin
                chk("wb_rd",   32'(wb_rd), 32'(m_ins[11:7]));
                chk("wb_data", wb_data,    m_res);
            end
            chk("alu_data1",  alu_data1,        m_d1);
            chk("alu_data2",  alu_data2,        m_d2);
            chk("alu_opcode", 32'(alu_opcode),  32'(m_op));
            chk("alu_funct3", 32'(alu_funct3),  32'(m_f3));
            chk("alu_funct7", 32'(alu_funct7),  32'(m_f7));
            chk("dbg_data",   dbg_data,         m_regs[dbg_addr]);

            m_ill = 1'b0;
            if (m_ph < 0) begin
                if (instr_valid) begin
                    m_ins = instr;
                    m_ph  = 0;
                end
            end else if (m_ph == 0) begin
                if (m_ins[6:0] == 7'b0110011 || m_ins[6:0] == 7'b0010011) begin
                    m_d1  = m_regs[m_ins[19:15]];
                    m_d2  = (m_ins[6:0] == 7'b0110011) ? m_regs[m_ins[24:20]] : sx12(m_ins[31:20]);
                    m_op  = 7'b0110011;
                    m_f3  = m_ins[14:12];
                    m_f7  = (m_ins[6:0] == 7'b0110011 || m_ins[14:12] == 3'd1 || m_ins[14:12] == 3'd5)
                            ? m_ins[31:25] : 7'd0;
                    m_res = rv_ref(m_ins, m_regs[m_ins[19:15]], m_regs[m_ins[24:20]]);
                    m_ph  = 1;
                end else begin
                    m_ill = 1'b1;
                    m_ph  = -1;
                end
            end else if (m_ph == 1) begin
                m_ph = 2;
            end else begin
                if (m_ins[11:7] != 5'd0) m_regs[m_ins[11:7]] = m_res;
                m_ph = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2, sh;
        logic [6:0]  f7, op;
        int          kind;
        kind = int'($urandom_range(0, 9));
        f3   = 3'($urandom);
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        sh   = 5'($urandom);
        if (kind == 0) begin
            op = 7'($urandom);
            while (op == 7'b0110011 || op == 7'b0010011) op = 7'($urandom);
            return {25'($urandom), op};
        end else if (kind < 5) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
            return enc_r(f7, rs2, rs1, f3, rd);
        end else begin
            if (f3 == 3'd1) return enc_i({7'd0, sh}, rs1, f3, rd);
            if (f3 == 3'd5) return enc_i({($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0, sh}, rs1, f3, rd);
            return enc_i(12'($urandom), rs1, f3, rd);
        end
    endfunction

    // Present an instruction until accepted; returns the cycle count after the accept edge.
    task automatic issue(input logic [31:0] ins, output int acc_cyc);
        int n;
        @(posedge clk); #1;
        instr = ins; instr_valid = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (instr_ready) break;
        end
        if (n == 20) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        acc_cyc = cyc;
        instr_valid = 1'b0; instr = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            if (instr_ready) break;
        end
        if (n == 10) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issue and pin the retire values to hand-computed literals.
    task automatic issue_wb(input logic [31:0] ins, input logic [4:0] exp_rd, input logic [31:0] exp_d);
        int n, c;
        issue(ins, c);
        for (n = 0; n < 8; n++) begin
            @(negedge clk);
            if (wb_valid) break;
        end
        if (n == 8) chk("wb_timeout", 32'd1, 32'd0);
        else begin
            chk("lit_wb_rd",   32'(wb_rd), 32'(exp_rd));
            chk("lit_wb_data", wb_data,    exp_d);
        end
        wait_idle();
    endtask

    task automatic dbg_lit(input logic [4:0] a, input logic [31:0] exp);
        @(posedge clk); #1; dbg_addr = a;
        @(negedge clk);
        chk("lit_dbg", dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        instr = '0; instr_valid = 1'b0; dbg_addr = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_rst", 32'(instr_ready), 32'd1);

        // ADDI x1,x0,0x555
        issue_wb(enc_i(12'h555, 5'd0, 3'd0, 5'd1), 5'd1, 32'h0000_0555);
        dbg_lit(5'd1, 32'h0000_0555);

        // x1 = 0x55555555, x2 = 0xAAAAAAAA via ADDI/SLLI/ORI
        issue_wb(enc_i(12'd12,  5'd1, 3'd1, 5'd1), 5'd1, 32'h0055_5000);
        issue_wb(enc_i(12'h555, 5'd1, 3'd6, 5'd1), 5'd1, 32'h0055_5555);
        issue_wb(enc_i(12'd8,   5'd1, 3'd1, 5'd1), 5'd1, 32'h5555_5500);
        issue_wb(enc_i(12'h055, 5'd1, 3'd6, 5'd1), 5'd1, 32'h5555_5555);
        issue_wb(enc_i(12'd1,   5'd1, 3'd1, 5'd2), 5'd2, 32'hAAAA_AAAA);
        issue_wb(enc_r(7'd0,        5'd2, 5'd1, 3'd0, 5'd3), 5'd3, 32'hFFFF_FFFF);
        issue_wb(enc_r(7'b0100000,  5'd1, 5'd2, 3'd0, 5'd4), 5'd4, 32'h5555_5555);

        // x1 = 0x03800155, then SLLI/SRLI by 4
        issue_wb(enc_i(12'h380, 5'd0, 3'd0, 5'd1), 5'd1, 32'h0000_0380);
        issue_wb(enc_i(12'd16,  5'd1, 3'd1, 5'd1), 5'd1, 32'h0380_0000);
        issue_wb(enc_i(12'h155, 5'd1, 3'd0, 5'd1), 5'd1, 32'h0380_0155);
        issue_wb(enc_i(12'd4,   5'd1, 3'd1, 5'd5), 5'd5, 32'h3800_1550);
        chk("lit_slli_f7", 32'(alu_funct7), 32'd0);
        issue_wb(enc_i(12'd4,   5'd1, 3'd5, 5'd5), 5'd5, 32'h0038_0015);
        chk("lit_srli_f7", 32'(alu_funct7), 32'd0);

        // ADDI x6,x0,-1 ; ADDI x0,x0,5
        issue_wb(enc_i(12'hFFF, 5'd0, 3'd0, 5'd6), 5'd6, 32'hFFFF_FFFF);
        issue_wb(enc_i(12'd5,   5'd0, 3'd0, 5'd0), 5'd0, 32'h0000_0005);
        dbg_lit(5'd0, 32'h0);

        // Unsupported opcode, followed back-to-back by a legal instruction.
        issue(32'h0000_0063, c0);
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd8), c1);
        chk("lit_illegal_next_accept", 32'(c1 - c0), 32'd2);
        wait_idle();
        dbg_lit(5'd8, 32'h0000_0007);

        // Reset during EXEC of ADDI x7,x0,9.
        issue(enc_i(12'd9, 5'd0, 3'd0, 5'd7), c0);
        @(posedge clk); #1 rst_n = 1'b0;
        dbg_addr = 5'd7;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_abort", 32'(instr_ready), 32'd1);
        chk("lit_x7_after_abort",    dbg_data,         32'd0);

        // Randomized stream; instr_valid is also driven while busy.
        repeat (8) issue(enc_i(12'($urandom), 5'd0, 3'd0, 5'($urandom_range(1, 7))), c0);
        wait_idle();
        repeat (1500) begin
            @(posedge clk); #1;
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = rand_instr();
            dbg_addr    = 5'($urandom);
        end
        @(posedge clk); #1 instr_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
